// File: rtl/pacman_motion_ctrl_pkg.sv
// Shared definitions for the Pac-Man motion engine: direction codes, tile encoding, FSM states.
package pacman_motion_ctrl_pkg;

  localparam logic [1:0] DIR_R = 2'd0;
  localparam logic [1:0] DIR_D = 2'd1;
  localparam logic [1:0] DIR_L = 2'd2;
  localparam logic [1:0] DIR_U = 2'd3;

  localparam int         TILE_SHIFT = 4;
  localparam logic [1:0] TILE_EMPTY = 2'd0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ALIGN_CHK,
    S_RD_WANT,
    S_WAIT_W,
    S_EV_W,
    S_RD_CUR,
    S_WAIT_C,
    S_EV_C,
    S_MOVE,
    S_STOP
  } state_e;

  // R<->L and D<->U differ only in bit 1 of the encoding.
  function automatic logic [1:0] opposite_dir(input logic [1:0] d);
    return d ^ 2'd2;
  endfunction

endpackage

// File: rtl/pacman_motion_ctrl_cell_lookup.sv
// Combinational neighbour-cell lookup: cell plus one step along dir, wrapped to the visible map.
module pacman_motion_ctrl_cell_lookup
  import pacman_motion_ctrl_pkg::*;
#(
  parameter int MAP_COLS = 30,
  parameter int MAP_ROWS = 30
) (
  input  logic [4:0] col,
  input  logic [4:0] row,
  input  logic [1:0] dir,
  output logic [9:0] addr
);

  localparam logic [4:0] LAST_COL = 5'(MAP_COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(MAP_ROWS - 1);

  logic [4:0] nb_col;
  logic [4:0] nb_row;

  always_comb begin
    nb_col = col;
    nb_row = row;
    case (dir)
      DIR_R:   nb_col = (col == LAST_COL) ? 5'd0 : col + 5'd1;
      DIR_L:   nb_col = (col == 5'd0) ? LAST_COL : col - 5'd1;
      DIR_D:   nb_row = (row == LAST_ROW) ? 5'd0 : row + 5'd1;
      default: nb_row = (row == 5'd0) ? LAST_ROW : row - 5'd1;
    endcase
    addr = {nb_row, nb_col};
  end

endmodule

// File: rtl/pacman_motion_ctrl.sv
// Per-frame Pac-Man movement engine: wall checks against tile RAM, buffered turns,
// wrapped stepping and mouth animation for the sprite renderer.
module pacman_motion_ctrl
  import pacman_motion_ctrl_pkg::*;
#(
  parameter int MAP_COLS  = 30,
  parameter int MAP_ROWS  = 30,
  parameter int START_COL = 14,
  parameter int START_ROW = 17,
  parameter int SPEED     = 1,
  parameter int ANIM_DIV  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       vsync,
  input  logic       joy_up,
  input  logic       joy_down,
  input  logic       joy_left,
  input  logic       joy_right,
  output logic       ram_rd,
  output logic [9:0] ram_addr,
  input  logic [7:0] ram_dout,
  output logic [8:0] pac_x,
  output logic [8:0] pac_y,
  output logic [1:0] pac_dir,
  output logic       moving,
  output logic [1:0] anim_frame
);

  localparam logic [8:0] X_SPAN    = 9'(MAP_COLS * 16);
  localparam logic [8:0] Y_SPAN    = 9'(MAP_ROWS * 16);
  localparam logic [8:0] X_START   = 9'(START_COL * 16);
  localparam logic [8:0] Y_START   = 9'(START_ROW * 16);
  localparam logic [8:0] SPD       = 9'(SPEED);
  localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);

  state_e     state_q, state_d;
  logic [2:0] vs_sh_q, vs_sh_d;
  logic [1:0] want_dir_q, want_dir_d;
  logic [1:0] chk_dir_q, chk_dir_d;
  logic [8:0] pac_x_q, pac_x_d;
  logic [8:0] pac_y_q, pac_y_d;
  logic [1:0] pac_dir_q, pac_dir_d;
  logic       moving_q, moving_d;
  logic [1:0] anim_q, anim_d;
  logic [7:0] anim_cnt_q, anim_cnt_d;
  logic [9:0] ram_addr_q, ram_addr_d;
  logic [1:0] tile_q, tile_d;

  logic       tick;
  logic       aligned;
  logic [4:0] cur_col;
  logic [4:0] cur_row;
  logic [9:0] want_addr;
  logic [9:0] cur_addr;
  logic       unused_dout;

  assign tick        = vs_sh_q[1] & ~vs_sh_q[2];
  assign aligned     = (pac_x_q[TILE_SHIFT-1:0] == '0) && (pac_y_q[TILE_SHIFT-1:0] == '0);
  assign cur_col     = pac_x_q[8:TILE_SHIFT];
  assign cur_row     = pac_y_q[8:TILE_SHIFT];
  assign unused_dout = ^ram_dout[7:2];

  pacman_motion_ctrl_cell_lookup #(.MAP_COLS(MAP_COLS), .MAP_ROWS(MAP_ROWS)) u_want_lookup (
    .col (cur_col),
    .row (cur_row),
    .dir (want_dir_q),
    .addr(want_addr)
  );

  pacman_motion_ctrl_cell_lookup #(.MAP_COLS(MAP_COLS), .MAP_ROWS(MAP_ROWS)) u_cur_lookup (
    .col (cur_col),
    .row (cur_row),
    .dir (pac_dir_q),
    .addr(cur_addr)
  );

  always_comb begin
    state_d    = state_q;
    vs_sh_d    = {vs_sh_q[1:0], vsync};
    want_dir_d = want_dir_q;
    chk_dir_d  = chk_dir_q;
    pac_x_d    = pac_x_q;
    pac_y_d    = pac_y_q;
    pac_dir_d  = pac_dir_q;
    moving_d   = moving_q;
    anim_d     = anim_q;
    anim_cnt_d = anim_cnt_q;
    ram_addr_d = ram_addr_q;
    tile_d     = tile_q;

    if (joy_up)         want_dir_d = DIR_U;
    else if (joy_down)  want_dir_d = DIR_D;
    else if (joy_left)  want_dir_d = DIR_L;
    else if (joy_right) want_dir_d = DIR_R;

    case (state_q)
      S_IDLE: if (tick && enable) state_d = S_ALIGN_CHK;
      S_ALIGN_CHK: begin
        if (want_dir_q == opposite_dir(pac_dir_q)) begin
          pac_dir_d = want_dir_q;
          state_d   = S_MOVE;
        end else if (!aligned) begin
          state_d = S_MOVE;
        end else begin
          // Remember the direction actually checked so a joystick change mid-check cannot turn us unverified.
          chk_dir_d  = want_dir_q;
          ram_addr_d = want_addr;
          state_d    = S_RD_WANT;
        end
      end
      S_RD_WANT: state_d = S_WAIT_W;
      S_WAIT_W: begin
        tile_d  = ram_dout[1:0];
        state_d = S_EV_W;
      end
      S_EV_W: begin
        if (tile_q == TILE_EMPTY) begin
          pac_dir_d = chk_dir_q;
          state_d   = S_MOVE;
        end else begin
          ram_addr_d = cur_addr;
          state_d    = S_RD_CUR;
        end
      end
      S_RD_CUR: state_d = S_WAIT_C;
      S_WAIT_C: begin
        tile_d  = ram_dout[1:0];
        state_d = S_EV_C;
      end
      S_EV_C: state_d = (tile_q == TILE_EMPTY) ? S_MOVE : S_STOP;
      S_MOVE: begin
        case (pac_dir_q)
          DIR_R:   pac_x_d = (pac_x_q >= X_SPAN - SPD) ? pac_x_q + SPD - X_SPAN : pac_x_q + SPD;
          DIR_L:   pac_x_d = (pac_x_q < SPD) ? pac_x_q + X_SPAN - SPD : pac_x_q - SPD;
          DIR_D:   pac_y_d = (pac_y_q >= Y_SPAN - SPD) ? pac_y_q + SPD - Y_SPAN : pac_y_q + SPD;
          default: pac_y_d = (pac_y_q < SPD) ? pac_y_q + Y_SPAN - SPD : pac_y_q - SPD;
        endcase
        moving_d = 1'b1;
        if (anim_cnt_q == ANIM_LAST) begin
          anim_cnt_d = 8'd0;
          anim_d     = anim_q + 2'd1;
        end else begin
          anim_cnt_d = anim_cnt_q + 8'd1;
        end
        state_d = S_IDLE;
      end
      S_STOP: begin
        moving_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      vs_sh_q    <= '0;
      want_dir_q <= DIR_L;
      chk_dir_q  <= DIR_L;
      pac_x_q    <= X_START;
      pac_y_q    <= Y_START;
      pac_dir_q  <= DIR_L;
      moving_q   <= 1'b0;
      anim_q     <= '0;
      anim_cnt_q <= '0;
      ram_addr_q <= '0;
      tile_q     <= '0;
    end else begin
      state_q    <= state_d;
      vs_sh_q    <= vs_sh_d;
      want_dir_q <= want_dir_d;
      chk_dir_q  <= chk_dir_d;
      pac_x_q    <= pac_x_d;
      pac_y_q    <= pac_y_d;
      pac_dir_q  <= pac_dir_d;
      moving_q   <= moving_d;
      anim_q     <= anim_d;
      anim_cnt_q <= anim_cnt_d;
      ram_addr_q <= ram_addr_d;
      tile_q     <= tile_d;
    end
  end

  assign ram_rd     = (state_q == S_RD_WANT) || (state_q == S_RD_CUR);
  assign ram_addr   = ram_addr_q;
  assign pac_x      = pac_x_q;
  assign pac_y      = pac_y_q;
  assign pac_dir    = pac_dir_q;
  assign moving     = moving_q;
  assign anim_frame = anim_q;

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// Scoreboard bench for pacman_motion_ctrl: a frame-level reference model pushes expected
// RAM reads and end-of-frame sprite state; monitors pop and compare against the DUT.
module tb_pacman_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       vsync = 1'b0;
  logic       joy_up = 1'b0, joy_down = 1'b0, joy_left = 1'b0, joy_right = 1'b0;
  logic       ram_rd;
  logic [9:0] ram_addr;
  logic [7:0] ram_dout;
  logic [8:0] pac_x, pac_y;
  logic [1:0] pac_dir;
  logic       moving;
  logic [1:0] anim_frame;

  always #5 clk = ~clk;

  pacman_motion_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .vsync     (vsync),
    .joy_up    (joy_up),
    .joy_down  (joy_down),
    .joy_left  (joy_left),
    .joy_right (joy_right),
    .ram_rd    (ram_rd),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .pac_x     (pac_x),
    .pac_y     (pac_y),
    .pac_dir   (pac_dir),
    .moving    (moving),
    .anim_frame(anim_frame)
  );

  // Tile RAM model, one cycle read latency; open tiles carry junk in the upper bits.
  logic [7:0] mem [0:1023];
  always @(posedge clk) ram_dout <= mem[ram_addr];

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic [1:0] dir;
    logic       mov;
    logic [1:0] anim;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] rd_q[$];
  int         total = 0;
  int         bad = 0;
  int         rd_cnt = 0;
  bit         ignore_rd = 1'b0;

  int m_x, m_y, m_dir, m_want, m_mov, m_anim, m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && ram_rd && !ignore_rd) begin
      rd_cnt++;
      if (rd_q.size() == 0) begin
        chk("rd_unexpected", 32'(ram_rd), 32'd0);
      end else begin
        logic [9:0] a;
        a = rd_q.pop_front();
        chk("rd_addr", 32'(ram_addr), 32'(a));
      end
    end
  end

  function automatic int nb_addr(input int col, input int row, input int dir);
    int c, r;
    c = col;
    r = row;
    case (dir)
      0: c = (col + 1) % 30;
      2: c = (col + 29) % 30;
      1: r = (row + 1) % 30;
      default: r = (row + 29) % 30;
    endcase
    return r * 32 + c;
  endfunction

  task automatic model_reset();
    m_x = 224; m_y = 272; m_dir = 2; m_want = 2; m_mov = 0; m_anim = 0; m_cnt = 0;
  endtask

  task automatic model_move();
    case (m_dir)
      0: m_x = (m_x + 1) % 480;
      2: m_x = (m_x + 479) % 480;
      1: m_y = (m_y + 1) % 480;
      default: m_y = (m_y + 479) % 480;
    endcase
    m_mov = 1;
    m_cnt++;
    if (m_cnt == 4) begin
      m_cnt = 0;
      m_anim = (m_anim + 1) % 4;
    end
  endtask

  task automatic model_tick(input bit en);
    int a;
    exp_t e;
    if (en) begin
      if (m_want == (m_dir ^ 2)) begin
        m_dir = m_want;
        model_move();
      end else if ((m_x % 16) != 0 || (m_y % 16) != 0) begin
        model_move();
      end else begin
        a = nb_addr(m_x / 16, m_y / 16, m_want);
        rd_q.push_back(10'(a));
        if (mem[a][1:0] == 2'd0) begin
          m_dir = m_want;
          model_move();
        end else begin
          a = nb_addr(m_x / 16, m_y / 16, m_dir);
          rd_q.push_back(10'(a));
          if (mem[a][1:0] == 2'd0) model_move();
          else m_mov = 0;
        end
      end
    end
    e.x = 9'(m_x); e.y = 9'(m_y); e.dir = 2'(m_dir); e.mov = 1'(m_mov); e.anim = 2'(m_anim);
    exp_q.push_back(e);
  endtask

  task automatic set_joy(input logic u, input logic d, input logic l, input logic r);
    joy_up = u; joy_down = d; joy_left = l; joy_right = r;
    if (u) m_want = 3;
    else if (d) m_want = 1;
    else if (l) m_want = 2;
    else if (r) m_want = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_tick();
    exp_t e;
    model_tick(enable);
    vsync = 1'b1;
    repeat (18) @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    e = exp_q.pop_front();
    chk("pac_x", 32'(pac_x), 32'(e.x));
    chk("pac_y", 32'(pac_y), 32'(e.y));
    chk("pac_dir", 32'(pac_dir), 32'(e.dir));
    chk("moving", 32'(moving), 32'(e.mov));
    chk("anim", 32'(anim_frame), 32'(e.anim));
    chk("rd_missing", 32'(rd_q.size()), 32'd0);
    rd_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    rd_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"}, 32'(pac_x), 32'd224);
    chk({tag, "_y"}, 32'(pac_y), 32'd272);
    chk({tag, "_dir"}, 32'(pac_dir), 32'd2);
    chk({tag, "_mov"}, 32'(moving), 32'd0);
    chk({tag, "_rd"}, 32'(ram_rd), 32'd0);
    chk({tag, "_anim"}, 32'(anim_frame), 32'd0);
  endtask

  initial begin
    int rd0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h80;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");

    // Open corridor: one aligned check on the first frame, then plain stepping.
    rd0 = rd_cnt;
    for (int i = 0; i < 16; i++) do_tick();
    chk("corridor_x", 32'(pac_x), 32'd208);
    chk("corridor_reads", 32'(rd_cnt - rd0), 32'd1);
    $display("corridor: x=%0d reads=%0d", pac_x, rd_cnt - rd0);

    // Reset in the middle of a check sequence.
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    ignore_rd = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("midreset_hold");
    reset = 1'b0;
    model_reset();
    rd_q.delete();
    repeat (2) @(negedge clk);
    ignore_rd = 1'b0;
    chk_reset_vals("midreset");
    $display("mid-sequence reset: x=%0d y=%0d", pac_x, pac_y);

    // Wall straight ahead: stop, no animation progress.
    mem[17*32+13] = 8'h01;
    for (int i = 0; i < 5; i++) do_tick();
    chk("wall_x", 32'(pac_x), 32'd224);
    chk("wall_mov", 32'(moving), 32'd0);
    chk("wall_anim", 32'(anim_frame), 32'd0);
    $display("wall: x=%0d moving=%0d", pac_x, moving);
    mem[17*32+13] = 8'h80;

    // Reversal while unaligned.
    do_reset();
    for (int i = 0; i < 4; i++) do_tick();
    set_joy(1'b0, 1'b0, 1'b0, 1'b1);
    do_tick();
    chk("rev_dir", 32'(pac_dir), 32'd0);
    chk("rev_x", 32'(pac_x), 32'd221);
    set_joy(1'b0, 1'b0, 1'b0, 1'b0);
    $display("reversal: dir=%0d x=%0d", pac_dir, pac_x);

    // Buffered turn into an open cell.
    do_reset();
    set_joy(1'b1, 1'b0, 1'b0, 1'b0);
    do_tick();
    chk("turn_dir", 32'(pac_dir), 32'd3);
    chk("turn_y", 32'(pac_y), 32'd271);
    set_joy(1'b0, 1'b0, 1'b0, 1'b0);
    $display("turn open: dir=%0d y=%0d", pac_dir, pac_y);

    // Turn blocked: keep going left with the request held until the next aligned cell.
    do_reset();
    mem[16*32+14] = 8'h01;
    set_joy(1'b1, 1'b0, 1'b0, 1'b0);
    set_joy(1'b0, 1'b0, 1'b0, 1'b0);
    do_tick();
    chk("blocked_dir", 32'(pac_dir), 32'd2);
    chk("blocked_x", 32'(pac_x), 32'd223);
    for (int i = 0; i < 16; i++) do_tick();
    chk("held_dir", 32'(pac_dir), 32'd3);
    chk("held_y", 32'(pac_y), 32'd271);
    mem[16*32+14] = 8'h80;
    $display("turn blocked then held: dir=%0d x=%0d y=%0d", pac_dir, pac_x, pac_y);

    // Tunnel wrap at the left edge, then freeze with enable low.
    do_reset();
    for (int i = 0; i < 224; i++) do_tick();
    chk("tunnel_pre_x", 32'(pac_x), 32'd0);
    do_tick();
    chk("tunnel_x", 32'(pac_x), 32'd479);
    $display("tunnel: x=%0d", pac_x);
    enable = 1'b0;
    rd0 = rd_cnt;
    for (int i = 0; i < 3; i++) do_tick();
    chk("frozen_x", 32'(pac_x), 32'd479);
    chk("frozen_reads", 32'(rd_cnt - rd0), 32'd0);
    $display("disabled: x=%0d reads=%0d", pac_x, rd_cnt - rd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
